// File: rtl/inst_align_pkg.sv
// Shared types and helpers for the instruction aligner and its word buffer.
package inst_align_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

  localparam logic [1:0] RVC_LEN_MASK = 2'b11;

  // A halfword starts a 16-bit instruction unless its length bits are 2'b11.
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != RVC_LEN_MASK;
  endfunction

endpackage

// File: rtl/inst_wbuf.sv
// Two-entry tagged instruction word buffer: FIFO replacement, two lookup
// ports (current word W, next word N), one write port and a flush.
module inst_wbuf
  import inst_align_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        we_i,
  input  logic [29:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [29:0] w_addr_i,
  output logic        w_hit_o,
  output logic [31:0] w_data_o,
  input  logic [29:0] n_addr_i,
  output logic        n_hit_o,
  output logic [31:0] n_data_o
);

  wbuf_entry_t ent_q [2];
  logic        wptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wptr_q   <= 1'b0;
    end else if (flush_i) begin
      ent_q[0].valid <= 1'b0;
      ent_q[1].valid <= 1'b0;
    end else if (we_i) begin
      ent_q[wptr_q] <= '{valid: 1'b1, addr: waddr_i, data: wdata_i};
      wptr_q        <= ~wptr_q;
    end
  end

  always_comb begin
    w_hit_o  = 1'b0;
    w_data_o = '0;
    n_hit_o  = 1'b0;
    n_data_o = '0;
    for (int i = 0; i < 2; i++) begin
      if (ent_q[i].valid && ent_q[i].addr == w_addr_i) begin
        w_hit_o  = 1'b1;
        w_data_o = ent_q[i].data;
      end
      if (ent_q[i].valid && ent_q[i].addr == n_addr_i) begin
        n_hit_o  = 1'b1;
        n_data_o = ent_q[i].data;
      end
    end
  end

endmodule

// File: rtl/inst_align.sv
// Instruction aligner between fetch PC and word-wide instruction memory.
// Define INST_ALIGN_COMPRESSED_EN for 16-bit and word-spanning instructions.
module inst_align
  import inst_align_pkg::*;
#(
  parameter int MEM_AW = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       fet_pc_i,
  input  logic              fet_redirect_i,
  input  logic              dec_ready_i,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic              com_inst_o,
  output logic              fet_en_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a request is held (mem_req_o/mem_addr_o stable) until the cycle
  // mem_gnt_i is high; exactly one mem_rvalid_i answers each grant; fetch
  // advances in every cycle where inst_valid_o and dec_ready_i are both high.

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e      state_q;
  logic        req_q;
  logic [29:0] req_addr_q;

  logic [29:0] w_addr, n_addr, miss_addr;
  logic        w_hit, n_hit, need_n, all_hit, com_hit, buf_we;
  logic [31:0] w_data, n_data, inst_hit;

  assign w_addr = fet_pc_i[31:2];
  assign n_addr = w_addr + 30'd1;
  assign buf_we = (state_q == ST_WAIT) && mem_rvalid_i && !fet_redirect_i;

  inst_wbuf u_wbuf (
    .clk_i    (clk_i),
    .rst_ni   (rst_n),
    .flush_i  (fet_redirect_i),
    .we_i     (buf_we),
    .waddr_i  (req_addr_q),
    .wdata_i  (mem_rdata_i),
    .w_addr_i (w_addr),
    .w_hit_o  (w_hit),
    .w_data_o (w_data),
    .n_addr_i (n_addr),
    .n_hit_o  (n_hit),
    .n_data_o (n_data)
  );

  always_comb begin
    need_n   = 1'b0;
    inst_hit = w_data;
    com_hit  = 1'b0;
`ifdef INST_ALIGN_COMPRESSED_EN
    if (!fet_pc_i[1]) begin
      if (is_rvc(w_data[15:0])) begin
        inst_hit = {16'h0, w_data[15:0]};
        com_hit  = 1'b1;
      end
    end else if (is_rvc(w_data[31:16])) begin
      inst_hit = {16'h0, w_data[31:16]};
      com_hit  = 1'b1;
    end else begin
      need_n   = 1'b1;
      inst_hit = {n_data[15:0], w_data[31:16]};
    end
`endif
  end

  assign all_hit   = w_hit && (!need_n || n_hit);
  assign miss_addr = !w_hit ? w_addr : n_addr;

  assign inst_valid_o = all_hit && (state_q == ST_IDLE);
  assign inst_o       = inst_valid_o ? inst_hit : 32'h0;
  assign com_inst_o   = inst_valid_o && com_hit;
  assign fet_en_o     = inst_valid_o && dec_ready_i;
  assign mem_req_o    = req_q;
  assign mem_addr_o   = MEM_AW'({req_addr_q, 2'b00});
  assign dbg_state_o  = state_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      req_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fet_redirect_i && !all_hit) begin
            req_addr_q <= miss_addr;
            req_q      <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (fet_redirect_i) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else if (mem_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A flush with the response in hand drops it; otherwise drain it later.
          if (fet_redirect_i) state_q <= mem_rvalid_i ? ST_IDLE : ST_DRAIN;
          else if (mem_rvalid_i) state_q <= ST_IDLE;
        end
        default: begin
          if (mem_rvalid_i) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  logic unused_sig;
  assign unused_sig = ^{fet_pc_i[1:0], n_data};

endmodule

// File: tb/tb_inst_align.sv
// Directed bench for inst_align: fetch scoreboard, request-order scoreboard
// and a one-outstanding memory responder with configurable response delay.
module tb_inst_align;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] fet_pc_i;
  logic        fet_redirect_i;
  logic        dec_ready_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        com_inst_o;
  logic        fet_en_o;
  logic [1:0]  dbg_state_o;

  inst_align #(.MEM_AW(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fet_pc_i       (fet_pc_i),
    .fet_redirect_i (fet_redirect_i),
    .dec_ready_i    (dec_ready_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .inst_o         (inst_o),
    .inst_valid_o   (inst_valid_o),
    .com_inst_o     (com_inst_o),
    .fet_en_o       (fet_en_o),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_q[$];       // {com, inst} per accepted fetch
  logic [31:0] exp_addr_q[$];  // expected memory request addresses in order

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0010: return 32'h4001_4501;
      32'h0000_0020: return 32'h0093_4501;
      32'h0000_0024: return 32'h1234_0050;
      32'h0000_0040: return 32'h0000_0013;
      32'h0000_0100: return 32'h00a0_0113;
      32'hFFFF_FFFC: return 32'h0093_0000;
      default:       return 32'h0;
    endcase
  endfunction

  // memory responder: grant while requested, answer after resp_delay cycles
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  int          resp_delay = 0;
  logic [31:0] pend_addr = '0;

  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (mem_gnt_i) begin
        pend = 1'b1; pend_cnt = resp_delay; pend_addr = mem_addr_o;
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_word(pend_addr);
          pend = 1'b0;
        end else pend_cnt--;
      end
      mem_gnt_i = mem_req_o && !pend;
      if (mem_gnt_i) begin
        if (exp_addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req actual=%0h required=none", mem_addr_o);
        end else chk("req_addr", mem_addr_o, exp_addr_q.pop_front());
      end
    end
  end

  // monitor: every accepted instruction is compared with the scoreboard
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk_i);
      if (fet_en_o) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_inst actual=%0h required=none", inst_o);
        end else begin
          e = exp_q.pop_front();
          chk("inst_com", {31'h0, com_inst_o, inst_o}, {31'h0, e});
        end
      end
    end
  end

  // driver: present pc, wait for acceptance, optionally check latency in cycles
  task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input logic ec,
                       input int exp_lat);
    int  n;
    bit  got;
    exp_q.push_back({ec, ei});
    fet_pc_i = pc; dec_ready_i = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      n++;
      if (fet_en_o) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL fetch_timeout pc=%0h actual=no_fet_en required=fet_en", pc);
      void'(exp_q.pop_back());
    end else if (exp_lat > 0) begin
      chk("latency", n, exp_lat);
    end
    @(posedge clk_i); #1;
    dec_ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] hold_inst;
    logic        hold_com;
    bit          got;
    int          n;

    rst_i = 1'b0; fet_pc_i = '0; fet_redirect_i = 1'b0; dec_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_com", com_inst_o, 0);
    chk("rst_fet_en", fet_en_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    exp_addr_q.push_back(32'h0);
    fetch(32'h0, 32'h0050_0093, 1'b0, 0);

`ifdef INST_ALIGN_COMPRESSED_EN
    exp_addr_q.push_back(32'h10);
    fetch(32'h10, 32'h0000_4501, 1'b1, 4);
    fetch(32'h12, 32'h0000_4001, 1'b1, 1);
    exp_addr_q.push_back(32'h20); exp_addr_q.push_back(32'h24);
    fetch(32'h22, 32'h0050_0093, 1'b0, 7);
    hold_inst = 32'h0000_4501; hold_com = 1'b1;
`else
    exp_addr_q.push_back(32'h10);
    fetch(32'h10, 32'h4001_4501, 1'b0, 4);
    fetch(32'h12, 32'h4001_4501, 1'b0, 1);
    exp_addr_q.push_back(32'h20);
    fetch(32'h22, 32'h0093_4501, 1'b0, 4);
    hold_inst = 32'h0093_4501; hold_com = 1'b0;
`endif

    // downstream stall on a hit: outputs hold, no advance, no state change
    exp_q.push_back({hold_com, hold_inst});
    fet_pc_i = 32'h20; dec_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("hold_valid", inst_valid_o, 1);
      chk("hold_inst", {com_inst_o, inst_o}, {hold_com, hold_inst});
      chk("hold_fet_en", fet_en_o, 0);
      chk("hold_state", dbg_state_o, 0);
    end
    @(posedge clk_i); #1;
    dec_ready_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk_i);
      if (fet_en_o) got = 1'b1;
    end
    chk("hold_release", got, 1);
    @(posedge clk_i); #1;
    dec_ready_i = 1'b0;

    // top-of-memory wrap
`ifdef INST_ALIGN_COMPRESSED_EN
    exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0);
    fetch(32'hFFFF_FFFE, 32'h0093_0093, 1'b0, 7);
`else
    exp_addr_q.push_back(32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFE, 32'h0093_0000, 1'b0, 4);
`endif

    // redirect while a response is outstanding: that response is dropped
    exp_addr_q.push_back(32'h40); exp_addr_q.push_back(32'h100);
    exp_q.push_back({1'b0, 32'h00a0_0113});
    resp_delay = 2;
    fet_pc_i = 32'h40; dec_ready_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (mem_req_o) got = 1'b1;
    end
    chk("flush_req_seen", got, 1);
    @(posedge clk_i); #1;
    fet_redirect_i = 1'b1; fet_pc_i = 32'h100;
    @(posedge clk_i); #1;
    fet_redirect_i = 1'b0; resp_delay = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("flush_no_valid", inst_valid_o, 0);
    end
    got = 1'b0; n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      n++;
      if (fet_en_o) got = 1'b1;
    end
    chk("flush_new_fetch", got, 1);
    @(posedge clk_i); #1;
    dec_ready_i = 1'b0;

    // the dropped word must not have been buffered
    exp_addr_q.push_back(32'h40);
    fetch(32'h40, 32'h0000_0013, 1'b0, 4);

    repeat (3) @(negedge clk_i);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", exp_addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_align.md
# inst_align

Instruction-side responder that sits between the fetch PC generator and instruction memory. Takes the current fetch PC and returns the instruction at that address, with its length and an advance strobe back to fetch. Holds a two-word buffer so halfword-aligned PCs, 16-bit compressed instructions and 32-bit instructions spanning a word boundary work against a word-wide memory. Supplies the `en_i` and `com_inst_i` inputs of the fetch stage.

## Interface
- `MEM_AW`, default 32: memory address width. Byte address; bits [1:0] are always driven 0.
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-low
- `fet_pc_i`  in  32  current fetch PC
- `fet_redirect_i`  in  1  fetch PC load (branch/jump) or trap this cycle; flush
- `dec_ready_i`  in  1  downstream accepts `inst_o` this cycle
- `mem_req_o`  out  1  word read request
- `mem_addr_o`  out  MEM_AW  word-aligned read address
- `mem_gnt_i`  in  1  request accepted
- `mem_rvalid_i`  in  1  read data valid
- `mem_rdata_i`  in  32  read data
- `inst_o`  out  32  instruction; compressed ones are zero-extended to 32 bits
- `inst_valid_o`  out  1  `inst_o` is valid for `fet_pc_i`
- `com_inst_o`  out  1  `inst_o` is 16-bit; drives fetch `com_inst_i`
- `fet_en_o`  out  1  `inst_valid_o & dec_ready_i`; drives fetch `en_i`

## Operation
- Buffer: 2 entries, each holding {valid, word address [31:2], data[31:0]}. Replacement is FIFO: the older entry is overwritten.
- Hit logic is combinational from the buffer registers and `fet_pc_i`. There is no combinational path from `mem_rdata_i` to `inst_o`.
  - `pc[1]=0`, word W hit: if `W[1:0]==2'b11`, `inst_o=W`, `com=0`. Otherwise `inst_o={16'h0,W[15:0]}`, `com=1`.
  - `pc[1]=1`, W hit: if `W[17:16]!=2'b11`, `inst_o={16'h0,W[31:16]}`, `com=1`. Otherwise the word at pc+4 (call it N) must also hit, and `inst_o={N[15:0],W[31:16]}`, `com=0`.
- `inst_valid_o` is high only when every word the instruction needs hits and the FSM is in IDLE.
- FSM states:
  - IDLE: on a miss, latch the missing word address (W first, then N) and go to REQ.
  - REQ: hold `mem_req_o` and `mem_addr_o` until `mem_gnt_i`, then go to WAIT.
  - WAIT: on `mem_rvalid_i`, write the buffer and go to IDLE.
  - DRAIN: on `mem_rvalid_i`, discard the data and go to IDLE.
- Flush (`fet_redirect_i`): invalidate both entries.
  - In REQ, drop the request and go to IDLE.
  - In WAIT, go to DRAIN.
  - A flush coinciding with `mem_rvalid_i` in WAIT discards that data.
- At most one outstanding request.
- `inst_o` and `com_inst_o` are 0 whenever `inst_valid_o=0`.

## Timing
- Reset values: `mem_req_o=0`, `mem_addr_o=0`, `inst_valid_o=0`, `inst_o=0`, `com_inst_o=0`, `fet_en_o=0`; both entries invalid; FSM in IDLE.
- Hit: `inst_valid_o` in the same cycle `fet_pc_i` is presented.
- Miss detected in cycle N:
  - `mem_req_o` is a registered output, high from N+1.
  - With grant at N+1 and rvalid at N+2, `inst_valid_o` rises at N+3.
- Spanning miss on both words: 2 sequential requests, the low word first.
- `dec_ready_i=0` with valid: outputs stay stable, `fet_en_o=0`, no state change.
- `mem_rvalid_i` in IDLE or REQ is a protocol error and is ignored.
- Address arithmetic is modulo 2^32: pc 0xFFFF_FFFE spanning reads word 0x0000_0000 as N.
- Reset is asynchronous on assertion. Release is synchronous to `clk_i` through a 2-flop synchronizer. An in-flight response after reset is ignored.

## Configuration
- `INST_ALIGN_COMPRESSED_EN` defined: behaviour as above.
- `INST_ALIGN_COMPRESSED_EN` undefined:
  - `fet_pc_i[1]` is ignored and every word is returned as a 32-bit instruction.
  - `com_inst_o` is tied 0.
  - The spanning path and its second request do not exist; only the W-hit path is used.

## Structure
- Shared package holds:
  - FSM state enum {IDLE, REQ, WAIT, DRAIN}
  - buffer entry struct
  - `RVC_LEN_MASK=2'b11` constant
  - function `is_rvc(halfword)`
- One natural sub-module: `inst_wbuf`. It holds the 2-entry tagged word buffer with FIFO replacement, two lookup ports (W, N), one write port and a flush input.

## Test plan
- Hold `rst_i=0`, then release with `fet_pc_i=0` → all outputs 0 during reset; `mem_req_o=1` and `mem_addr_o=0` 1 cycle after the miss.
- Word 0x00 = 0x00500093, pc 0x00 → `inst_o=0x00500093`, `com_inst_o=0`, `fet_en_o=1` with `dec_ready_i=1`.
- Word 0x10 = 0x40014501:
  - pc 0x10 → `inst_o=0x00004501`, `com=1`.
  - pc 0x12 → `inst_o=0x00004001`, `com=1`, with no new `mem_req_o`.
- Word 0x20 = 0x00934501, word 0x24 = 0x12340050, pc 0x22 → requests to 0x20 then 0x24; `inst_o=0x00500093`, `com=0`.
- Pc 0x40 miss with grant given; `fet_redirect_i` pulses before rvalid; new pc 0x100 → data returned for 0x40 is discarded, `inst_valid_o` stays 0, next `mem_addr_o=0x100`.
- `dec_ready_i=0` for 3 cycles on a hit → `inst_o` stable, `fet_en_o=0`. Without the macro, pc 0x12 yields word 0x10 and `com_inst_o=0`.
